// File: rtl/switch_out_queue_pkg.sv
// Shared constants, helpers and types for the switch output stage.
package switch_out_pkg;

    localparam int unsigned N_PORTS_DEF  = 4;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned AF_LEVEL_DEF = 6;
    localparam int unsigned CNT_W_DEF    = 8;

    // $clog2 that never returns 0, so a single-port build still has a 1-bit index
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [clog2_min1(N_PORTS_DEF)-1:0] port_idx_t;

endpackage

// File: rtl/switch_out_queue_if.sv
// Fabric-side write bus and per-port consumer handshake for switch_out_queue.
interface switch_out_queue_if
    import switch_out_pkg::*;
#(
    parameter int unsigned N_PORTS = N_PORTS_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);
    localparam int unsigned IDX_W = clog2_min1(N_PORTS);

    logic                             in_valid;
    logic [IDX_W-1:0]                 in_port;
    logic [DATA_W-1:0]                in_data;
    logic [N_PORTS-1:0]               in_full;
    logic                             dest_err;
    logic [N_PORTS-1:0][DATA_W-1:0]   port_out;
    logic [N_PORTS-1:0]               port_ready;
    logic [N_PORTS-1:0]               port_read;
    logic [N_PORTS-1:0][CNT_W-1:0]    drop_cnt;

    modport master (
        output in_valid, in_port, in_data, port_read,
        input  in_full, dest_err, port_out, port_ready, drop_cnt
    );

    modport slave (
        input  in_valid, in_port, in_data, port_read,
        output in_full, dest_err, port_out, port_ready, drop_cnt
    );

    modport monitor (
        input in_valid, in_port, in_data, port_read,
        input in_full, dest_err, port_out, port_ready, drop_cnt
    );

endinterface

// File: rtl/switch_out_queue_chan.sv
// One output channel: first-word-fall-through FIFO, almost-full flag and
// saturating drop counter.
module out_chan_fifo
    import switch_out_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned AF_LEVEL = AF_LEVEL_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              almost_full,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0] count, count_nxt;
    logic                full, pop, accept, drop;

    assign ready   = (count != '0);
    assign rd_data = ready ? mem[rd_ptr] : '0;

    // A full channel still accepts a write when the head leaves on the same edge.
    always_comb begin
        full      = (count == CNT_BITS'(DEPTH));
        pop       = ready & rd_en;
        accept    = wr_en & (~full | pop);
        drop      = wr_en & full & ~pop;
        count_nxt = count;
        if (accept && !pop)
            count_nxt = count + CNT_BITS'(1);
        else if (pop && !accept)
            count_nxt = count - CNT_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= CNT_BITS'(AF_LEVEL));
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/switch_out_queue.sv
// N-channel switch output stage: destination decode, bad-destination flag and
// one out_chan_fifo per port.
module switch_out_queue
    import switch_out_pkg::*;
#(
    parameter int unsigned N_PORTS  = N_PORTS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned AF_LEVEL = AF_LEVEL_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    switch_out_queue_if.slave bus
);
    localparam int unsigned IDX_W = clog2_min1(N_PORTS);

    logic bad_dest;
    logic dest_err_q;

    // Out-of-range indices exist only when N_PORTS is not a power of two.
    if (N_PORTS == (1 << IDX_W)) begin : g_pow2
        assign bad_dest = 1'b0;
    end else begin : g_npow2
        assign bad_dest = bus.in_valid && (bus.in_port >= IDX_W'(N_PORTS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dest_err_q <= 1'b0;
        else
            dest_err_q <= bad_dest;
    end

    assign bus.dest_err = dest_err_q;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_chan
        out_chan_fifo #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (bus.in_valid && (bus.in_port == IDX_W'(p))),
            .wr_data     (bus.in_data),
            .rd_en       (bus.port_read[p]),
            .rd_data     (bus.port_out[p]),
            .ready       (bus.port_ready[p]),
            .almost_full (bus.in_full[p]),
            .drop_cnt    (bus.drop_cnt[p])
        );
    end

endmodule

// File: tb/tb_switch_out_queue.sv
// Directed and random checks of switch_out_queue (4-port and 3-port builds)
// against per-port queue models.
module tb_switch_out_queue;
    import switch_out_pkg::*;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_port = '0;
    logic [7:0] in_data = '0;
    logic [3:0] port_read = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    switch_out_queue_if #(.N_PORTS(4), .DATA_W(8), .CNT_W(8)) bus4 ();
    switch_out_queue_if #(.N_PORTS(3), .DATA_W(8), .CNT_W(8)) bus3 ();

    assign bus4.in_valid  = in_valid;
    assign bus4.in_port   = in_port;
    assign bus4.in_data   = in_data;
    assign bus4.port_read = port_read;
    assign bus3.in_valid  = in_valid;
    assign bus3.in_port   = in_port;
    assign bus3.in_data   = in_data;
    assign bus3.port_read = port_read[2:0];

    switch_out_queue #(.N_PORTS(4), .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .CNT_W(8)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );
    switch_out_queue #(.N_PORTS(3), .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .CNT_W(8)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    always #5 clk = ~clk;

    // Model: index d*4+p, d=0 is the 4-port build, d=1 the 3-port build.
    logic [7:0]  mq [8][$];
    int unsigned mdrop [8];
    logic        mderr [2];

    function automatic int nports(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic string tg(input string s, input int d, input int p);
        return $sformatf("%s[%0d][%0d]", s, d, p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mq[i].delete();
            mdrop[i] = 0;
        end
        mderr[0] = 1'b0;
        mderr[1] = 1'b0;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            mderr[d] = in_valid && (32'(in_port) >= 32'(nports(d)));
            for (int p = 0; p < nports(d); p++) begin
                int  i;
                bit  popq, was_full;
                i        = d * 4 + p;
                was_full = (mq[i].size() == DEPTH);
                popq     = (mq[i].size() != 0) && port_read[p];
                if (popq)
                    void'(mq[i].pop_front());
                if (in_valid && 32'(in_port) == 32'(p)) begin
                    if (!was_full || popq)
                        mq[i].push_back(in_data);
                    else if (mdrop[i] != 255)
                        mdrop[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] rdy, af;
        logic       de;
        logic [7:0] outv, dc, exp_out;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                rdy = bus4.port_ready; af = bus4.in_full; de = bus4.dest_err;
            end else begin
                rdy = {1'b0, bus3.port_ready}; af = {1'b0, bus3.in_full}; de = bus3.dest_err;
            end
            chk(tg("dest_err", d, 0), 32'(de), 32'(mderr[d]));
            for (int p = 0; p < nports(d); p++) begin
                int i;
                i = d * 4 + p;
                if (d == 0) begin
                    outv = bus4.port_out[p]; dc = bus4.drop_cnt[p];
                end else begin
                    outv = bus3.port_out[p]; dc = bus3.drop_cnt[p];
                end
                exp_out = (mq[i].size() != 0) ? mq[i][0] : 8'h00;
                chk(tg("port_ready", d, p), 32'(rdy[p]), 32'(mq[i].size() != 0));
                chk(tg("port_out", d, p), 32'(outv), 32'(exp_out));
                chk(tg("in_full", d, p), 32'(af[p]), 32'(mq[i].size() >= AF));
                chk(tg("drop_cnt", d, p), 32'(dc), mdrop[i]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cyc(input logic v, input logic [1:0] pt, input logic [7:0] dt,
                       input logic [3:0] rd);
        in_valid  = v;
        in_port   = pt;
        in_data   = dt;
        port_read = rd;
        step();
    endtask

    // Called just after an edge; asserts reset between edges.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all();
        chk("rst_ready4", 32'(bus4.port_ready), 32'h0);
        chk("rst_drop4_0", 32'(bus4.drop_cnt[0]), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        rst = 1'b1;
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write then pop
        cyc(1'b1, 2'd2, 8'hA5, 4'b0000);
        chk("t1_ready", 32'(bus4.port_ready), 32'h4);
        chk("t1_out", 32'(bus4.port_out[2]), 32'hA5);
        cyc(1'b0, 2'd0, 8'h00, 4'b0100);
        chk("t1_pop_ready", 32'(bus4.port_ready[2]), 32'h0);
        chk("t1_pop_out", 32'(bus4.port_out[2]), 32'h0);

        // Fill and overflow port 0
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 2'd0, 8'(i), 4'b0000);
            if (i == 4) chk("t2_af_low", 32'(bus4.in_full[0]), 32'h0);
            if (i == 5) chk("t2_af_high", 32'(bus4.in_full[0]), 32'h1);
        end
        chk("t2_drop", 32'(bus4.drop_cnt[0]), 32'h2);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", 32'(bus4.port_out[0]), 32'(i));
            cyc(1'b0, 2'd0, 8'h00, 4'b0001);
        end

        // Full port plus simultaneous pop and write
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 2'd1, 8'(8'h10 + i), 4'b0000);
        cyc(1'b1, 2'd1, 8'h55, 4'b0010);
        chk("t3_drop", 32'(bus4.drop_cnt[1]), 32'h0);
        chk("t3_full", 32'(bus4.in_full[1]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", 32'(bus4.port_out[1]), (i == 7) ? 32'h55 : 32'(8'h11 + i));
            cyc(1'b0, 2'd0, 8'h00, 4'b0010);
        end

        // Write into empty port while its read is held
        cyc(1'b1, 2'd3, 8'h3C, 4'b1000);
        chk("t4_ready", 32'(bus4.port_ready[3]), 32'h1);
        chk("t4_out", 32'(bus4.port_out[3]), 32'h3C);
        cyc(1'b0, 2'd0, 8'h00, 4'b1000);
        chk("t4_empty", 32'(bus4.port_ready[3]), 32'h0);

        // Bad destination on the 3-port build
        cyc(1'b1, 2'd3, 8'hFF, 4'b0000);
        chk("t5_derr", 32'(bus3.dest_err), 32'h1);
        chk("t5_ready3", 32'(bus3.port_ready), 32'h0);
        cyc(1'b0, 2'd0, 8'h00, 4'b1000);
        chk("t5_derr_off", 32'(bus3.dest_err), 32'h0);

        // Asynchronous reset mid-traffic
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'd0, 8'(8'h40 + i), 4'b0000);
            cyc(1'b1, 2'd1, 8'(8'h50 + i), 4'b0000);
        end
        mid_reset();
        cyc(1'b1, 2'd0, 8'h11, 4'b0000);
        chk("t6_out", 32'(bus4.port_out[0]), 32'h11);
        cyc(1'b0, 2'd0, 8'h00, 4'b0011);
        chk("t6_empty", 32'(bus4.port_ready), 32'h0);

        // Drop counter saturation
        for (int i = 0; i < 270; i++)
            cyc(1'b1, 2'd2, 8'(i), 4'b0000);
        chk("sat_drop", 32'(bus4.drop_cnt[2]), 32'hFF);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 2'd0, 8'h00, 4'b0100);

        // Random traffic: sparse reads first, then balanced
        for (int k = 0; k < 400; k++) begin
            logic [3:0] rd;
            rd = (k < 200) ? (4'($urandom) & 4'($urandom)) : 4'($urandom);
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), rd);
            if (k == 300) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
